// File: rtl/aes_pkg.sv
// Shared word/block geometry and packer state type for the receive-side AES buffer.
package aes_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } pack_state_t;

  // W3 rolls back to W0 through the natural 2-bit wrap.
  function automatic pack_state_t next_pack_state(input pack_state_t s);
    logic [1:0] nxt;
    nxt = s + 2'd1;
    return pack_state_t'(nxt);
  endfunction

endpackage

// File: rtl/rcv_pack_fifo_if.sv
// Word-in / block-out bus of rcv_pack_fifo. almost_full exists only when ALMOST_FULL_EN is defined.
interface rcv_pack_fifo_if
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               clear;
  logic               wr_en;
  logic [WORD_W-1:0]  wr_data;
  logic               wr_ready;
  logic               deq;
  logic [BLOCK_W-1:0] fifo_out;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [1:0]         word_idx;
  logic               overflow_err;
`ifdef ALMOST_FULL_EN
  logic               almost_full;
`endif

  modport master (
    output clear, wr_en, wr_data, deq,
    input  wr_ready, fifo_out, full, empty, count, word_idx, overflow_err
`ifdef ALMOST_FULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  clear, wr_en, wr_data, deq,
    output wr_ready, fifo_out, full, empty, count, word_idx, overflow_err
`ifdef ALMOST_FULL_EN
    , output almost_full
`endif
  );

endinterface

// File: rtl/rcv_pack_fifo_mem.sv
// fifo_mem: DEPTH x BLOCK_W register file, one synchronous write port, one asynchronous read port.
module fifo_mem
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [BLOCK_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; unread entries are masked by the count/empty logic in the parent.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rcv_pack_fifo.sv
// rcv_pack_fifo: packs 4 x 32-bit words into 128-bit blocks and queues them in a FWFT FIFO.
// Optional almost_full output is built when ALMOST_FULL_EN is defined.
module rcv_pack_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           n_reset,
  rcv_pack_fifo_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int PACK_W = BLOCK_W - WORD_W;

  pack_state_t        state;
  logic [PACK_W-1:0]  pack_q;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;

  logic               full;
  logic               empty;
  logic               wr_ready;
  logic               accept;
  logic               push;
  logic               pop;
  logic [BLOCK_W-1:0] rdata;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  // Only the closing word needs FIFO room; earlier words sit in the packer.
  assign wr_ready = !((state == W3) && full);

  assign accept = bus.wr_en && wr_ready && !bus.clear;
  assign push   = accept && (state == W3);
  assign pop    = bus.deq && !empty && !bus.clear;

  fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata ({pack_q, bus.wr_data}),
    .raddr (rptr),
    .rdata (rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= W0;
      pack_q  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      state   <= W0;
      pack_q  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        unique case (state)
          W0: pack_q[PACK_W-1          -: WORD_W] <= bus.wr_data;
          W1: pack_q[PACK_W-1-WORD_W   -: WORD_W] <= bus.wr_data;
          W2: pack_q[PACK_W-1-2*WORD_W -: WORD_W] <= bus.wr_data;
          W3: pack_q <= pack_q;
        endcase
        state <= next_pack_state(state);
      end

      if (bus.wr_en && !wr_ready) ovf_q <= 1'b1;

      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.word_idx     = state;
  assign bus.overflow_err = ovf_q;
  assign bus.fifo_out     = empty ? '0 : rdata;

`ifdef ALMOST_FULL_EN
  assign bus.almost_full  = (count_q >= CNT_W'(DEPTH - 1));
`endif

endmodule
